// File: rtl/bus_grant_controller_pkg.sv
// Shared arbiter definitions: grant FSM state encodings and client index constants.
package bus_grant_controller_pkg;

    localparam int NUM_CLIENTS = 4;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'b00,
        ST_IDLE    = 2'b01,
        ST_GRANT   = 2'b10,
        ST_RELEASE = 2'b11
    } state_e;

    localparam logic [1:0] CLIENT_1 = 2'b00;
    localparam logic [1:0] CLIENT_2 = 2'b01;
    localparam logic [1:0] CLIENT_3 = 2'b10;
    localparam logic [1:0] CLIENT_4 = 2'b11;

    function automatic logic [NUM_CLIENTS-1:0] client_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_grant_controller.sv
// Grants the bus to the client picked by the upstream priority arbiter and forwards
// its words to the server until last-word, burst limit or idle timeout.
module bus_grant_controller
    import bus_grant_controller_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    address_to_be_served,
    input  logic [NUM_CLIENTS-1:0]        client_rq,
    input  logic [NUM_CLIENTS-1:0]        client_valid,
    input  logic [NUM_CLIENTS-1:0]        client_last,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_data,
    input  logic                          server_ready,
    output logic [NUM_CLIENTS-1:0]        client_gnt,
    output logic [NUM_CLIENTS-1:0]        client_ready,
    output logic                          server_valid,
    output logic [DATA_W-1:0]             server_data,
    output logic [1:0]                    server_src,
    output logic                          server_ack,
    output logic                          timeout_err
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [3:0] TIMEOUT_C   = 4'(TIMEOUT);

    state_e                   state_q, state_d;
    logic [1:0]               settle_q, settle_d;
    logic [1:0]               sel_q, sel_d;
    logic [3:0]               words_q, words_d;
    logic [3:0]               idle_q, idle_d;
    logic [NUM_CLIENTS-1:0]   gnt_q, gnt_d;
    logic [1:0]               src_q, src_d;
    logic                     ack_q, ack_d;
    logic                     terr_q, terr_d;

    logic [NUM_CLIENTS-1:0][DATA_W-1:0] client_words;
    logic                               in_grant;
    logic                               sel_valid;
    logic                               sel_last;
    logic                               xfer;

    assign client_words = client_data;
    assign in_grant     = (state_q == ST_GRANT);
    assign sel_valid    = client_valid[sel_q];
    assign sel_last     = client_last[sel_q];
    assign xfer         = in_grant && sel_valid && server_ready;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        words_d  = words_q;
        idle_d   = idle_q;
        ack_d    = 1'b0;
        terr_d   = 1'b0;
        case (state_q)
            // Covers the arbiter's two-cycle address update after reset or ack.
            ST_SETTLE: begin
                if (settle_q == 2'd1) begin
                    settle_d = 2'd0;
                    state_d  = ST_IDLE;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            ST_IDLE: begin
                if (client_rq[address_to_be_served]) begin
                    sel_d   = address_to_be_served;
                    words_d = 4'd0;
                    idle_d  = 4'd0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    words_d = words_q + 4'd1;
                    idle_d  = 4'd0;
                    if (sel_last || (words_d == MAX_BURST_C)) begin
                        state_d = ST_RELEASE;
                        ack_d   = 1'b1;
                    end
                end else if (!sel_valid) begin
                    // A stalled server (valid without ready) does not count as idle.
                    idle_d = idle_q + 4'd1;
                    if (idle_d == TIMEOUT_C) begin
                        state_d = ST_RELEASE;
                        ack_d   = 1'b1;
                        terr_d  = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                settle_d = 2'd0;
                state_d  = ST_SETTLE;
            end
            default: begin
                settle_d = 2'd0;
                state_d  = ST_SETTLE;
            end
        endcase
        gnt_d = (state_d == ST_GRANT) ? client_onehot(sel_d) : '0;
        src_d = (state_d == ST_GRANT) ? sel_d : 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SETTLE;
            settle_q <= 2'd0;
            sel_q    <= 2'd0;
            words_q  <= 4'd0;
            idle_q   <= 4'd0;
            gnt_q    <= '0;
            src_q    <= 2'd0;
            ack_q    <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            words_q  <= words_d;
            idle_q   <= idle_d;
            gnt_q    <= gnt_d;
            src_q    <= src_d;
            ack_q    <= ack_d;
            terr_q   <= terr_d;
        end
    end

    // Zero-latency datapath; state_q resets to SETTLE so this clears asynchronously.
    always_comb begin
        server_valid = 1'b0;
        server_data  = '0;
        client_ready = '0;
        if (in_grant) begin
            server_valid        = sel_valid;
            server_data         = client_words[sel_q];
            client_ready[sel_q] = server_ready;
        end
    end

    assign client_gnt  = gnt_q;
    assign server_src  = src_q;
    assign server_ack  = ack_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_grant_controller.sv
// Directed and randomized grants checked against a per-grant transfer model.
module tb_bus_grant_controller;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 8;

    logic                clk;
    logic                reset;
    logic [1:0]          address_to_be_served;
    logic [3:0]          client_rq;
    logic [3:0]          client_valid;
    logic [3:0]          client_last;
    logic [4*DATA_W-1:0] client_data;
    logic                server_ready;
    logic [3:0]          client_gnt;
    logic [3:0]          client_ready;
    logic                server_valid;
    logic [DATA_W-1:0]   server_data;
    logic [1:0]          server_src;
    logic                server_ack;
    logic                timeout_err;

    bus_grant_controller #(
        .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .address_to_be_served(address_to_be_served),
        .client_rq(client_rq), .client_valid(client_valid),
        .client_last(client_last), .client_data(client_data),
        .server_ready(server_ready),
        .client_gnt(client_gnt), .client_ready(client_ready),
        .server_valid(server_valid), .server_data(server_data),
        .server_src(server_src), .server_ack(server_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Per-cycle stimulus of the granted client, indexed by grant cycle.
    bit         dv [64];
    bit         dl [64];
    bit         dr [64];
    logic [7:0] dd [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            dv[i] = 1'b0; dl[i] = 1'b0; dr[i] = 1'b1; dd[i] = 8'($urandom);
        end
    endtask

    task automatic fill_random(input int pv, input int pr, input int pl);
        for (int i = 0; i < 64; i++) begin
            dv[i] = ($urandom_range(99) < pv);
            dr[i] = ($urandom_range(99) < pr);
            dl[i] = ($urandom_range(99) < pl);
            dd[i] = 8'($urandom);
        end
    endtask

    // Other clients, the address and the request lines get noise: none may matter in GRANT.
    task automatic drive_cycle(input int idx, input int k);
        logic [3:0]  v, l;
        logic [31:0] d;
        v = 4'($urandom); l = 4'($urandom); d = $urandom;
        v[idx] = dv[k];
        l[idx] = dl[k];
        d[idx*8 +: 8] = dd[k];
        client_valid         = v;
        client_last          = l;
        client_data          = d;
        server_ready         = dr[k];
        address_to_be_served = 2'($urandom);
        client_rq            = 4'($urandom);
    endtask

    task automatic start_grant(input int idx, input int exp_w);
        logic [3:0] oh;
        int w;
        oh = 4'b0001 << idx;
        address_to_be_served = 2'(idx);
        client_rq    = 4'($urandom) | oh;
        client_valid = 4'b0;
        client_last  = 4'b0;
        server_ready = 1'b0;
        w = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            w++;
            if (client_gnt !== 4'b0) break;
        end
        chk("grant_latency", w, exp_w);
        chk("grant_onehot", {28'b0, client_gnt}, {28'b0, oh});
        chk("grant_src", {30'b0, server_src}, idx);
    endtask

    // Model: a transfer is valid&ready; a grant ends on last/burst-limit transfer
    // or after TIMEOUT cycles without valid since the last transfer.
    task automatic run_grant(input int idx, input string name, output int n_xfer);
        logic [3:0] oh;
        int  words, idle, last_k, obs_x;
        bit  done, to, xfer;
        oh = 4'b0001 << idx;
        words = 0; idle = 0; last_k = 0; obs_x = 0; done = 0; to = 0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            drive_cycle(idx, k);
            xfer = dv[k] && dr[k];
            if (xfer) begin words++; idle = 0; end
            else if (!dv[k]) idle++;
            @(negedge clk);
            chk({name, ":gnt"},   {28'b0, client_gnt}, {28'b0, oh});
            chk({name, ":src"},   {30'b0, server_src}, idx);
            chk({name, ":valid"}, {31'b0, server_valid}, {31'b0, dv[k]});
            chk({name, ":data"},  {24'b0, server_data}, {24'b0, dd[k]});
            chk({name, ":ready"}, {28'b0, client_ready}, dr[k] ? {28'b0, oh} : 32'b0);
            chk({name, ":ack0"},  {31'b0, server_ack}, 0);
            if (server_valid && client_ready[idx]) obs_x++;
            last_k = k;
            if (xfer && (dl[k] || words == MAX_BURST)) begin done = 1; to = 0; break; end
            if (!dv[k] && idle == TIMEOUT) begin done = 1; to = 1; break; end
        end
        chk({name, ":ended"}, {31'b0, done}, 1);
        @(posedge clk); #1;
        drive_cycle(idx, last_k + 1);
        @(negedge clk);
        chk({name, ":ack"},     {31'b0, server_ack}, 1);
        chk({name, ":timeout"}, {31'b0, timeout_err}, {31'b0, to});
        chk({name, ":rel_gnt"}, {28'b0, client_gnt}, 0);
        chk({name, ":rel_vld"}, {31'b0, server_valid}, 0);
        chk({name, ":rel_rdy"}, {28'b0, client_ready}, 0);
        chk({name, ":rel_dat"}, {24'b0, server_data}, 0);
        chk({name, ":xfers"},   obs_x, words);
        n_xfer = obs_x;
    endtask

    initial begin
        int nx;
        reset = 1'b1;
        address_to_be_served = 2'd0;
        client_rq = 4'b0; client_valid = 4'b0; client_last = 4'b0;
        client_data = '0; server_ready = 1'b0;
        #3;
        chk("rst_gnt", {28'b0, client_gnt}, 0);
        chk("rst_ack", {31'b0, server_ack}, 0);
        chk("rst_terr", {31'b0, timeout_err}, 0);
        // Outputs stay quiet under reset even with live inputs.
        client_rq = 4'hF; client_valid = 4'hF; server_ready = 1'b1;
        client_data = $urandom; address_to_be_served = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt_live", {28'b0, client_gnt}, 0);
        chk("rst_vld_live", {31'b0, server_valid}, 0);
        chk("rst_rdy_live", {28'b0, client_ready}, 0);
        chk("rst_dat_live", {24'b0, server_data}, 0);
        chk("rst_src_live", {30'b0, server_src}, 0);

        // Grant 3 cycles of settle/idle after release, visible in the 4th cycle.
        reset = 1'b0;
        start_grant(2, 3);
        fill_random(70, 70, 20);
        run_grant(2, "first", nx);

        // Client 2: three words, last on the third, server always ready.
        start_grant(1, 4);
        clear_stim();
        dv[0] = 1; dv[1] = 1; dv[2] = 1;
        dd[0] = 8'h11; dd[1] = 8'h22; dd[2] = 8'h33; dl[2] = 1;
        run_grant(1, "three_words", nx);
        chk("three_words:count", nx, 3);

        // Addressed client not requesting: stay idle with no grant.
        address_to_be_served = 2'd0;
        client_rq = 4'b1110; client_valid = 4'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_no_rq", {28'b0, client_gnt}, 0);
        end
        start_grant(0, 1);

        // Six words, no last: burst limit cuts the grant.
        clear_stim();
        for (int i = 0; i < 6; i++) dv[i] = 1;
        run_grant(0, "burst", nx);
        chk("burst:count", nx, MAX_BURST);

        // Client 4 silent: idle timeout.
        start_grant(3, 4);
        clear_stim();
        run_grant(3, "timeout", nx);
        chk("timeout:count", nx, 0);

        // Server stalls 5 cycles: data held, no transfer, no timeout.
        start_grant(0, 4);
        clear_stim();
        for (int i = 0; i < 6; i++) begin dv[i] = 1; dd[i] = 8'hA5; dr[i] = (i == 5); end
        dl[5] = 1;
        run_grant(0, "stall", nx);
        chk("stall:count", nx, 1);

        // Last word coincides with burst limit.
        start_grant(2, 4);
        clear_stim();
        for (int i = 0; i < 4; i++) dv[i] = 1;
        dl[3] = 1;
        run_grant(2, "last_at_max", nx);

        for (int it = 0; it < 30; it++) begin
            int idx;
            idx = $urandom_range(3);
            start_grant(idx, 4);
            fill_random($urandom_range(100, 30), $urandom_range(100, 30), 15);
            run_grant(idx, "rand", nx);
        end

        // Reset during the second word of a grant.
        start_grant(1, 4);
        clear_stim();
        for (int i = 0; i < 4; i++) dv[i] = 1;
        drive_cycle(1, 0);
        @(negedge clk);
        chk("midrst:pre_gnt", {28'b0, client_gnt}, 32'h2);
        @(posedge clk); #1;
        drive_cycle(1, 1);
        #2;
        chk("midrst:pre_vld", {31'b0, server_valid}, 1);
        reset = 1'b1;
        #1;
        chk("midrst:gnt", {28'b0, client_gnt}, 0);
        chk("midrst:vld", {31'b0, server_valid}, 0);
        chk("midrst:ack", {31'b0, server_ack}, 0);
        chk("midrst:rdy", {28'b0, client_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        client_rq = 4'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("postrst:ack", {31'b0, server_ack}, 0);
            chk("postrst:gnt", {28'b0, client_gnt}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
